// File: rtl/uart_ext.sv
// UART with 1-char TX holding register, RX FIFO (first-word fall-through) and sticky error flags.
// Optional parity bit on TX and RX is compiled in with `define UART_EXT_PARITY_EN.
module uart_ext #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int RX_DEPTH   = 16,
    parameter int PARITY_ODD = 0,
    localparam int LW        = $clog2(RX_DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 tx_busy_o,
    input  logic                 rd_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 rx_ready_o,
    output logic [LW-1:0]        rx_level_o,
    input  logic                 err_clr_i,
    output logic                 rx_frame_err_o,
    output logic                 rx_ovf_o,
    output logic                 rx_par_err_o,
    input  logic                 rxd_i,
    output logic                 txd_o
);
    localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
    localparam int DIVIDER = BIT_CYC - 1;
    localparam int CW      = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
    localparam int BW      = $clog2(DATA_BITS);
    localparam int PW      = $clog2(RX_DEPTH);
    localparam logic [CW-1:0] DIV_C     = CW'(DIVIDER);
    localparam logic [CW-1:0] HALF_C    = CW'(DIVIDER / 2);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);
    localparam logic          ODD_C     = (PARITY_ODD != 0);
`ifdef UART_EXT_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 tx_state_q, tx_state_d;
    logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]          tx_bit_q, tx_bit_d;
    logic                   tx_stop_q, tx_stop_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_par_q, tx_par_d;
    logic                   txd_q, txd_d;
    logic                   tx_busy_q, tx_busy_d;

    state_t                 rx_state_q, rx_state_d;
    logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]          rx_bit_q, rx_bit_d;
    logic                   rx_stop_q, rx_stop_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic                   rx_par_bad_q, rx_par_bad_d;
    logic                   rx_armed_q, rx_armed_d;
    logic                   rx_s1_q, rx_s2_q;
    logic                   push_req, frame_evt, par_evt;

    logic [DATA_BITS-1:0]   mem_q [RX_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   frame_err_q, frame_err_d, ovf_q, ovf_d, par_err_q, par_err_d;
    logic                   full, empty, push, pop, ovf_evt;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_stop_d  = tx_stop_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        tx_busy_d  = tx_busy_q;
        if (tx_state_q == IDLE) begin
            if (wr_i) begin
                tx_shift_d = data_i;
                tx_par_d   = (^data_i) ^ ODD_C;
                tx_state_d = START;
                tx_cnt_d   = '0;
                txd_d      = 1'b0;
                tx_busy_d  = 1'b1;
            end
        end else if (tx_cnt_q != DIV_C) begin
            tx_cnt_d = tx_cnt_q + CW'(1);
        end else begin
            // Bit period elapsed: present the next bit on the line.
            tx_cnt_d = '0;
            case (tx_state_q)
                START: begin
                    tx_state_d = DATA;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                end
                DATA: begin
                    if (tx_bit_q == LAST_BIT) begin
                        if (PAR_EN) begin
                            tx_state_d = PARITY;
                            txd_d      = tx_par_q;
                        end else begin
                            tx_state_d = STOP;
                            tx_stop_d  = 1'b0;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + BW'(1);
                        tx_shift_d = tx_shift_q >> 1;
                        txd_d      = tx_shift_q[1];
                    end
                end
                PARITY: begin
                    tx_state_d = STOP;
                    tx_stop_d  = 1'b0;
                    txd_d      = 1'b1;
                end
                STOP: begin
                    if (tx_stop_q == LAST_STOP) begin
                        tx_state_d = IDLE;
                        tx_busy_d  = 1'b0;
                        txd_d      = 1'b1;
                    end else begin
                        tx_stop_d = 1'b1;
                    end
                end
                default: tx_state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_stop_d    = rx_stop_q;
        rx_shift_d   = rx_shift_q;
        rx_par_bad_d = rx_par_bad_q;
        rx_armed_d   = rx_armed_q;
        push_req     = 1'b0;
        frame_evt    = 1'b0;
        par_evt      = 1'b0;
        case (rx_state_q)
            // After a framing error the line must be seen high before a new start is accepted.
            IDLE: begin
                rx_armed_d = rx_armed_q | rx_s2_q;
                if (rx_armed_q && !rx_s2_q) begin
                    rx_state_d = START;
                    rx_cnt_d   = '0;
                end
            end
            START: begin
                if (rx_cnt_q == HALF_C) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? IDLE : DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: begin
                if (rx_cnt_q != DIV_C) begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end else begin
                    rx_cnt_d = '0;
                    case (rx_state_q)
                        DATA: begin
                            rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                            if (rx_bit_q == LAST_BIT) begin
                                rx_stop_d    = 1'b0;
                                rx_par_bad_d = 1'b0;
                                rx_state_d   = PAR_EN ? PARITY : STOP;
                            end else begin
                                rx_bit_d = rx_bit_q + BW'(1);
                            end
                        end
                        PARITY: begin
                            rx_par_bad_d = rx_s2_q ^ (^rx_shift_q) ^ ODD_C;
                            rx_state_d   = STOP;
                        end
                        STOP: begin
                            if (!rx_s2_q) begin
                                frame_evt  = 1'b1;
                                rx_armed_d = 1'b0;
                                rx_state_d = IDLE;
                            end else if (rx_stop_q == LAST_STOP) begin
                                par_evt    = rx_par_bad_q;
                                push_req   = !rx_par_bad_q;
                                rx_state_d = IDLE;
                            end else begin
                                rx_stop_d = 1'b1;
                            end
                        end
                        default: rx_state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    always_comb begin
        empty       = (level_q == '0);
        full        = (level_q == LW'(RX_DEPTH));
        pop         = rd_i && !empty;
        push        = push_req && (!full || pop);
        ovf_evt     = push_req && full && !pop;
        wr_ptr_d    = wr_ptr_q + PW'(push);
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        level_d     = level_q + LW'(push) - LW'(pop);
        frame_err_d = (frame_err_q & ~err_clr_i) | frame_evt;
        ovf_d       = (ovf_q & ~err_clr_i) | ovf_evt;
        par_err_d   = (par_err_q & ~err_clr_i) | par_evt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state_q  <= IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_stop_q   <= 1'b0;
            txd_q       <= 1'b1;
            tx_busy_q   <= 1'b0;
            rx_state_q  <= IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_stop_q   <= 1'b0;
            rx_armed_q  <= 1'b1;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            frame_err_q <= 1'b0;
            ovf_q       <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_stop_q   <= tx_stop_d;
            txd_q       <= txd_d;
            tx_busy_q   <= tx_busy_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_stop_q   <= rx_stop_d;
            rx_armed_q  <= rx_armed_d;
            rx_s1_q     <= rxd_i;
            rx_s2_q     <= rx_s1_q;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            frame_err_q <= frame_err_d;
            ovf_q       <= ovf_d;
            par_err_q   <= par_err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        tx_shift_q   <= tx_shift_d;
        tx_par_q     <= tx_par_d;
        rx_shift_q   <= rx_shift_d;
        rx_par_bad_q <= rx_par_bad_d;
        if (push) begin
            mem_q[wr_ptr_q] <= rx_shift_q;
        end
    end

    assign txd_o          = txd_q;
    assign tx_busy_o      = tx_busy_q;
    assign data_o         = empty ? '0 : mem_q[rd_ptr_q];
    assign rx_ready_o     = !empty;
    assign rx_level_o     = level_q;
    assign rx_frame_err_o = frame_err_q;
    assign rx_ovf_o       = ovf_q;
    assign rx_par_err_o   = PAR_EN ? par_err_q : 1'b0;
endmodule
